// File: rtl/ones_pattern_gen.sv
// ones_pattern_gen: serial thermometer-code generator, builds a WIDTH-bit word with N ones one bit per clock.
// Define ONES_GEN_MSB_FIRST_EN to fill from the MSB instead of the LSB.
module ones_pattern_gen #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s,
    input  logic [CW-1:0]    count,
    output logic [WIDTH-1:0] pattern,
    output logic             done,
    output logic             err
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [CW-1:0] WMAX = CW'(WIDTH);

    logic [1:0]       state;
    logic [CW-1:0]    rem;
    logic             over;
    logic [WIDTH-1:0] shifted;

    assign over = count > WMAX;
    assign done = state == DONE;
`ifdef ONES_GEN_MSB_FIRST_EN
    assign shifted = {1'b1, pattern[WIDTH-1:1]};
`else
    assign shifted = {pattern[WIDTH-2:0], 1'b1};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pattern <= '0;
            rem     <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rem <= over ? WMAX : count;
                    err <= over;
                    if (s) begin
                        state   <= FILL;
                        pattern <= '0;
                    end
                end
                FILL: begin
                    if (rem == '0) begin
                        state <= DONE;
                    end else begin
                        pattern <= shifted;
                        rem     <= rem - CW'(1);
                    end
                end
                DONE: if (!s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ones_pattern_gen.sv
// tb_ones_pattern_gen: directed stimulus with a scoreboard checked on each rising edge of done.
module tb_ones_pattern_gen;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         s = 1'b0;
    logic [3:0]   count = '0;
    logic [W-1:0] pattern;
    logic         done;
    logic         err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [W-1:0] p;
        logic         e;
        int           t;
    } exp_t;
    exp_t sb[$];

    ones_pattern_gen #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .s(s), .count(count),
        .pattern(pattern), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [W-1:0] thermo(input int n);
`ifdef ONES_GEN_MSB_FIRST_EN
        logic [15:0] v = 16'hFF00 >> n;
`else
        logic [15:0] v = (16'd1 << n) - 16'd1;
`endif
        return v[W-1:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // expected completion: done first seen at the negedge after E(N+1)
    task automatic start(input logic [3:0] n);
        exp_t e;
        int nc = (n > 4'd8) ? 8 : int'(n);
        count = n;
        s = 1'b1;
        e.p = thermo(nc);
        e.e = n > 4'd8;
        e.t = cyc + nc + 2;
        sb.push_back(e);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got done=0 expected done=1 within 30 cycles");
        end
    endtask

    initial begin : monitor
        exp_t e;
        logic done_d = 1'b0;
        forever begin
            @(negedge clk);
            if (done === 1'b1 && done_d !== 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_done: got done=1 expected no completion");
                end else begin
                    e = sb.pop_front();
                    chk("sb_pattern", 32'(pattern), 32'(e.p));
                    chk("sb_err", 32'(err), 32'(e.e));
                    chk("sb_latency", 32'(cyc), 32'(e.t));
                end
            end
            done_d = done;
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_pattern", 32'(pattern), 0);
            chk("idle_done", 32'(done), 0);
            chk("idle_err", 32'(err), 0);
        end
        start(4'd3);
        @(negedge clk);
        s = 1'b0;
        chk("n3_e0_clear", 32'(pattern), 0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk($sformatf("n3_step%0d", i), 32'(pattern), 32'(thermo(i)));
            chk("n3_busy", 32'(done), 0);
        end
        @(negedge clk);
        chk("n3_done", 32'(done), 1);
        @(negedge clk);
        chk("n3_back_idle", 32'(done), 0);
        start(4'd0);
        @(negedge clk);
        s = 1'b0;
        wait_done();
        @(negedge clk);
        start(4'd8);
        @(negedge clk);
        s = 1'b0;
        wait_done();
        @(negedge clk);
        count = 4'd12;
        @(negedge clk);
        chk("clamp_err_idle", 32'(err), 1);
        start(4'd12);
        @(negedge clk);
        s = 1'b0;
        count = 4'd1;
        @(negedge clk);
        chk("clamp_err_frozen", 32'(err), 1);
        wait_done();
        @(negedge clk);
        @(negedge clk);
        chk("err_tracks_idle", 32'(err), 0);
        start(4'd4);
        wait_done();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_done", 32'(done), 1);
            chk("hold_pattern", 32'(pattern), 32'(thermo(4)));
        end
        s = 1'b0;
        @(negedge clk);
        chk("release_done", 32'(done), 0);
        start(4'd2);
        @(negedge clk);
        s = 1'b0;
        chk("restart_clear", 32'(pattern), 0);
        wait_done();
        @(negedge clk);
        start(4'd5);
        @(negedge clk);
        s = 1'b0;
        @(negedge clk);
        chk("n5_e1", 32'(pattern), 32'(thermo(1)));
        reset = 1'b1;
        @(negedge clk);
        chk("rst_pattern", 32'(pattern), 0);
        chk("rst_done", 32'(done), 0);
        reset = 1'b0;
        void'(sb.pop_back());
        count = 4'd7;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_rst_done", 32'(done), 0);
            chk("post_rst_pattern", 32'(pattern), 0);
        end
        chk("sb_empty", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
